// File: rtl/seq_divider_32_pkg.sv
//------------------------------------------------------------------------------
// seq_divider_32_pkg : shared widths, state encoding and helpers for the divider
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package seq_divider_32_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;
  localparam logic [WIDTH-1:0] DBZ_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             as_signed);
    return (as_signed && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_divider_32_if.sv
//------------------------------------------------------------------------------
// seq_divider_32_if : request/result bundle between control unit and divider
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface seq_divider_32_if;
  import seq_divider_32_pkg::*;

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

`default_nettype wire

// File: rtl/seq_divider_32_div_step.sv
//------------------------------------------------------------------------------
// seq_divider_32_div_step : one combinational restoring shift/subtract step
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seq_divider_32_div_step
  import seq_divider_32_pkg::*;
#(
  parameter int STEP_W = WIDTH
) (
  input  wire logic [STEP_W-1:0] rem_i,
  input  wire logic              q_msb_i,
  input  wire logic [STEP_W-1:0] div_i,
  output logic      [STEP_W-1:0] rem_o,
  output logic                   q_bit_o
);

  logic [STEP_W:0] w_p;
  logic            w_ge;

  assign w_p     = {rem_i, q_msb_i};
  assign w_ge    = (w_p >= {1'b0, div_i});
  assign q_bit_o = w_ge;
  // When P >= D the true difference is below D, so its low bits are exact.
  assign rem_o   = w_ge ? (w_p[STEP_W-1:0] - div_i) : w_p[STEP_W-1:0];

endmodule

`default_nettype wire

// File: rtl/seq_divider_32.sv
//------------------------------------------------------------------------------
// seq_divider_32 : 34-cycle restoring divider for MIPS DIV/DIVU (LO=q, HI=r)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seq_divider_32
  import seq_divider_32_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        reset,
  seq_divider_32_if.slave  bus
);

  state_e           state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [WIDTH-1:0] rem_q,       rem_d;
  logic [WIDTH-1:0] quo_q,       quo_d;
  logic [WIDTH-1:0] den_q,       den_d;
  logic [WIDTH-1:0] dvd_raw_q,   dvd_raw_d;
  logic             neg_quo_q,   neg_quo_d;
  logic             neg_rem_q,   neg_rem_d;
  logic             dbz_q,       dbz_d;
  logic [WIDTH-1:0] quotient_q,  quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_out_q,   dbz_out_d;

  logic [WIDTH-1:0] w_rem_next;
  logic             w_q_bit;

  seq_divider_32_div_step #(
    .STEP_W (WIDTH)
  ) u_step (
    .rem_i   (rem_q),
    .q_msb_i (quo_q[WIDTH-1]),
    .div_i   (den_q),
    .rem_o   (w_rem_next),
    .q_bit_o (w_q_bit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      den_q       <= '0;
      dvd_raw_q   <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dbz_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      den_q       <= den_d;
      dvd_raw_q   <= dvd_raw_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      dbz_q       <= dbz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_out_q   <= dbz_out_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    den_d       = den_q;
    dvd_raw_d   = dvd_raw_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    dbz_d       = dbz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_out_d   = dbz_out_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d   = RUN;
          cnt_d     = '0;
          rem_d     = '0;
          quo_d     = magnitude(bus.dividend, bus.is_signed);
          den_d     = magnitude(bus.divisor, bus.is_signed);
          dvd_raw_d = bus.dividend;
          neg_quo_d = bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
          neg_rem_d = bus.is_signed & bus.dividend[WIDTH-1];
          dbz_d     = (bus.divisor == '0);
        end else begin
          state_d   = IDLE;
        end
      end
      RUN: begin
        rem_d = w_rem_next;
        quo_d = {quo_q[WIDTH-2:0], w_q_bit};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        state_d = DONE;
        if (dbz_q) begin
          quotient_d  = DBZ_QUOTIENT;
          remainder_d = dvd_raw_q;
          dbz_out_d   = 1'b1;
        end else begin
          quotient_d  = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
          remainder_d = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
          dbz_out_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy        = (state_q == RUN) || (state_q == FIX);
  assign bus.done        = (state_q == DONE);
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_out_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider_32.sv
//------------------------------------------------------------------------------
// tb_seq_divider_32 : directed and randomized self-checking bench for the divider
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_seq_divider_32;
  import seq_divider_32_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  seq_divider_32_if bus();

  seq_divider_32 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.is_signed = sgn;
    bus.dividend  = a;
    bus.divisor   = b;
  endtask

  // Drops start after one cycle; lat is the cycle done was first seen, -1 on timeout.
  task automatic wait_done(output int lat, output bit busy_ok);
    lat     = -1;
    busy_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        lat = k;
        if (bus.busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.quotient !== 32'h0) begin failures++; $display("FAIL reset_quotient got=%h exp=0", bus.quotient); end
    checks++; if (bus.remainder !== 32'h0) begin failures++; $display("FAIL reset_remainder got=%h exp=0", bus.remainder); end
    checks++; if (bus.div_by_zero !== 1'b0) begin failures++; $display("FAIL reset_dbz got=%b exp=0", bus.div_by_zero); end
    reset = 1'b0;
  endtask

  task automatic test_unsigned();
    int lat; bit bok;
    start_op(1'b0, 32'd100, 32'd7);
    wait_done(lat, bok);
    checks++; if (lat !== 34) begin failures++; $display("FAIL udiv_latency got=%0d exp=34", lat); end
    checks++; if (bok !== 1'b1) begin failures++; $display("FAIL udiv_busy_window got=%b exp=1", bok); end
    checks++; if (bus.quotient !== 32'd14) begin failures++; $display("FAIL udiv_quotient got=%h exp=%h", bus.quotient, 32'd14); end
    checks++; if (bus.remainder !== 32'd2) begin failures++; $display("FAIL udiv_remainder got=%h exp=%h", bus.remainder, 32'd2); end
    checks++; if (bus.div_by_zero !== 1'b0) begin failures++; $display("FAIL udiv_dbz got=%b exp=0", bus.div_by_zero); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL udiv_done_pulse got=%b exp=0", bus.done); end
  endtask

  task automatic test_signed();
    int lat; bit bok;
    start_op(1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_done(lat, bok);
    checks++; if (lat !== 34) begin failures++; $display("FAIL sdiv_a_latency got=%0d exp=34", lat); end
    checks++; if (bus.quotient !== 32'hFFFF_FFFD) begin failures++; $display("FAIL sdiv_a_quotient got=%h exp=fffffffd", bus.quotient); end
    checks++; if (bus.remainder !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sdiv_a_remainder got=%h exp=ffffffff", bus.remainder); end
    start_op(1'b1, 32'd7, 32'hFFFF_FFFE);
    wait_done(lat, bok);
    checks++; if (bus.quotient !== 32'hFFFF_FFFD) begin failures++; $display("FAIL sdiv_b_quotient got=%h exp=fffffffd", bus.quotient); end
    checks++; if (bus.remainder !== 32'd1) begin failures++; $display("FAIL sdiv_b_remainder got=%h exp=00000001", bus.remainder); end
  endtask

  task automatic test_div_by_zero();
    int lat; bit bok;
    for (int m = 0; m < 2; m++) begin
      start_op(m[0], 32'h1234_5678, 32'h0);
      wait_done(lat, bok);
      checks++; if (lat !== 34) begin failures++; $display("FAIL dbz%0d_latency got=%0d exp=34", m, lat); end
      checks++; if (bus.quotient !== 32'hFFFF_FFFF) begin failures++; $display("FAIL dbz%0d_quotient got=%h exp=ffffffff", m, bus.quotient); end
      checks++; if (bus.remainder !== 32'h1234_5678) begin failures++; $display("FAIL dbz%0d_remainder got=%h exp=12345678", m, bus.remainder); end
      checks++; if (bus.div_by_zero !== 1'b1) begin failures++; $display("FAIL dbz%0d_flag got=%b exp=1", m, bus.div_by_zero); end
    end
  endtask

  task automatic test_extremes();
    int lat; bit bok;
    start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat, bok);
    checks++; if (bus.quotient !== 32'h8000_0000) begin failures++; $display("FAIL minneg_quotient got=%h exp=80000000", bus.quotient); end
    checks++; if (bus.remainder !== 32'h0) begin failures++; $display("FAIL minneg_remainder got=%h exp=0", bus.remainder); end
    checks++; if (bus.div_by_zero !== 1'b0) begin failures++; $display("FAIL minneg_dbz got=%b exp=0", bus.div_by_zero); end
    start_op(1'b0, 32'hFFFF_FFFF, 32'd1);
    wait_done(lat, bok);
    checks++; if (bus.quotient !== 32'hFFFF_FFFF) begin failures++; $display("FAIL umax_quotient got=%h exp=ffffffff", bus.quotient); end
    checks++; if (bus.remainder !== 32'h0) begin failures++; $display("FAIL umax_remainder got=%h exp=0", bus.remainder); end
  endtask

  task automatic test_start_while_busy();
    int lat = -1;
    start_op(1'b0, 32'd1000, 32'd10);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (k == 10) begin
        bus.start = 1'b1; bus.dividend = 32'd5; bus.divisor = 32'd1;
      end
      if (k == 11) bus.start = 1'b0;
      if (bus.done === 1'b1) begin lat = k; break; end
    end
    checks++; if (lat !== 34) begin failures++; $display("FAIL midstart_latency got=%0d exp=34", lat); end
    checks++; if (bus.quotient !== 32'd100) begin failures++; $display("FAIL midstart_quotient got=%h exp=%h", bus.quotient, 32'd100); end
    checks++; if (bus.remainder !== 32'd0) begin failures++; $display("FAIL midstart_remainder got=%h exp=0", bus.remainder); end
  endtask

  task automatic test_reset_mid_run();
    int lat; bit bok; bit saw_done = 1'b0;
    start_op(1'b0, 32'd500, 32'd3);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.quotient !== 32'h0) begin failures++; $display("FAIL midreset_quotient got=%h exp=0", bus.quotient); end
    checks++; if (bus.remainder !== 32'h0) begin failures++; $display("FAIL midreset_remainder got=%h exp=0", bus.remainder); end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL midreset_no_done got=%b exp=0", saw_done); end
    start_op(1'b0, 32'd50, 32'd5);
    wait_done(lat, bok);
    checks++; if (lat !== 34) begin failures++; $display("FAIL postreset_latency got=%0d exp=34", lat); end
    checks++; if (bus.quotient !== 32'd10) begin failures++; $display("FAIL postreset_quotient got=%h exp=%h", bus.quotient, 32'd10); end
  endtask

  task automatic test_back_to_back();
    int first = -1, second = -1;
    logic [31:0] q1 = 'x, r1 = 'x, q2 = 'x, r2 = 'x;
    start_op(1'b0, 32'd1000, 32'd7);
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      // Only the start seen in the DONE cycle may pick these up.
      if (k == 1) begin bus.dividend = 32'd77; bus.divisor = 32'd7; end
      if (bus.done === 1'b1) begin
        if (first < 0) begin
          first = k; q1 = bus.quotient; r1 = bus.remainder;
        end else begin
          second = k; q2 = bus.quotient; r2 = bus.remainder;
          bus.start = 1'b0;
          break;
        end
      end
    end
    bus.start = 1'b0;
    checks++; if (first !== 34) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=34", first); end
    checks++; if (q1 !== 32'd142 || r1 !== 32'd6) begin failures++; $display("FAIL b2b_first_result got=%h/%h exp=%h/%h", q1, r1, 32'd142, 32'd6); end
    checks++; if (second !== 68) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=68", second); end
    checks++; if (q2 !== 32'd11 || r2 !== 32'd0) begin failures++; $display("FAIL b2b_second_result got=%h/%h exp=%h/%h", q2, r2, 32'd11, 32'd0); end
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL b2b_idle_after got=%b exp=0", bus.busy); end
  endtask

  task automatic test_random();
    int lat; bit bok;
    logic [31:0] a, b, eq, er;
    logic signed [31:0] sa, sb;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 150; i++) begin
        a = $urandom;
        b = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(1, 1000));
        if ($urandom_range(0, 3) == 0) b = ~b + 1'b1;
        if (b == 32'h0) b = 32'd3;
        if (m == 1 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd2;
        if (m == 1) begin
          sa = a; sb = b;
          eq = sa / sb; er = sa % sb;
        end else begin
          eq = a / b; er = a % b;
        end
        start_op(m[0], a, b);
        wait_done(lat, bok);
        checks++;
        if (lat !== 34 || bus.quotient !== eq || bus.remainder !== er) begin
          failures++;
          $display("FAIL random_m%0d a=%h b=%h got=%h/%h lat=%0d exp=%h/%h lat=34",
                   m, a, b, bus.quotient, bus.remainder, lat, eq, er);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_by_zero();
    test_extremes();
    test_start_while_busy();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
